// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state encoding and helpers for rr_arbiter4
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Index of the set bit of a one-hot vector; zero for an all-zero vector.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority winner search over four requests
module rr_pick4 (
    input  logic [3:0]                 req,
    input  logic [arb_pkg::SEL_W-1:0]  last_owner,
    output logic [arb_pkg::SEL_W-1:0]  winner,
    output logic                       any_req
);

    logic [1:0] start;
    logic [3:0] rot;
    logic [1:0] pick;

    // Rotate so the requester after last_owner sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        start = last_owner + 2'd1;
        case (start)
            2'd0:    rot = req;
            2'd1:    rot = {req[0],   req[3:1]};
            2'd2:    rot = {req[1:0], req[3:2]};
            default: rot = {req[2:0], req[3]};
        endcase
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) begin
                pick = 2'(i);
            end
        end
        winner  = pick + start;
        any_req = |req;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - locking round-robin arbiter for the shared 4:1 mux; optional forced release with ARB_TIMEOUT_EN
module rr_arbiter4 #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [arb_pkg::SEL_W-1:0]   sel,
    output logic                        busy,
    output logic                        preempt
);
    import arb_pkg::*;

    if (NUM_REQ != arb_pkg::NUM_REQ) begin : g_bad_num_req
        $error("rr_arbiter4 supports exactly four requesters");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter4 MAX_HOLD must be within 2..255");
    end

    arb_state_e          state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    last_owner_q;
    logic                busy_q;

    logic [SEL_W-1:0]    winner_d;
    logic                any_req_d;
    logic [NUM_REQ-1:0]  win_oh_d;
    logic                owner_req;

    rr_pick4 u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (winner_d),
        .any_req    (any_req_d)
    );

    assign win_oh_d  = NUM_REQ'(1) << winner_d;
    assign owner_req = req[sel_q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q;
    logic       preempt_q;
    logic       others_req;

    // Another requester is waiting while the owner holds the mux.
    assign others_req = |(req & ~gnt_q);
    assign preempt    = preempt_q;
`else
    assign preempt    = 1'b0;
`endif

    // Arbitration FSM: grant from IDLE, hold while owner requests, release with one idle bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            sel_q        <= '0;
            busy_q       <= 1'b0;
            last_owner_q <= 2'd3;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q   <= '0;
            preempt_q    <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            preempt_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (any_req_d) begin
                        gnt_q   <= win_oh_d;
                        sel_q   <= onehot_to_idx(win_oh_d);
                        busy_q  <= 1'b1;
                        state_q <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_q <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    if (!owner_req) begin
                        gnt_q        <= '0;
                        busy_q       <= 1'b0;
                        last_owner_q <= sel_q;
                        state_q      <= ST_IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt_q == HOLD_LAST && others_req) begin
                        gnt_q        <= '0;
                        busy_q       <= 1'b0;
                        last_owner_q <= sel_q;
                        state_q      <= ST_IDLE;
                        preempt_q    <= 1'b1;
                    end else if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
`endif
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - self-checking bench for rr_arbiter4 (both ARB_TIMEOUT_EN builds)
module tb_rr_arbiter4;

    localparam int MAXH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    rr_arbiter4 #(.NUM_REQ(4), .MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the mux, who owned it last, how many cycles the grant has been visible.
    bit         m_busy;
    bit         m_pre;
    int         m_sel;
    int         m_last;
    int         m_len;
    logic [3:0] m_others;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_pre  = 1'b0;
            m_sel  = 0;
            m_last = 3;
            m_len  = 0;
        end else begin
            m_pre = 1'b0;
            if (!m_busy) begin
                for (int k = 1; k <= 4; k++) begin
                    if (!m_busy && req[(m_last + k) % 4]) begin
                        m_busy = 1'b1;
                        m_sel  = (m_last + k) % 4;
                        m_len  = 1;
                    end
                end
            end else begin
                m_others = req;
                m_others[m_sel] = 1'b0;
                if (!req[m_sel]) begin
                    m_busy = 1'b0;
                    m_last = m_sel;
                end else if (TO && m_len >= MAXH && m_others != 4'b0000) begin
                    m_busy = 1'b0;
                    m_last = m_sel;
                    m_pre  = 1'b1;
                end else begin
                    m_len = m_len + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model, on the falling edge.
    always @(negedge clk) begin : cmp
        logic [3:0] eg;
        eg = 4'b0000;
        if (m_busy) eg[m_sel] = 1'b1;
        if (chk_en) begin
            chk("model_gnt", gnt, eg);
            chk("model_sel", sel, 32'(m_sel));
            chk("model_busy", busy, m_busy);
            chk("model_preempt", preempt, m_pre);
        end
    end

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;

        // reset with all requests high
        step(4'b1111);
        chk_en = 1'b1;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_sel", sel, 2'b00);
        chk("rst_busy", busy, 1'b0);
        step(4'b1111);
        chk("rst2_gnt", gnt, 4'b0000);
        rst = 1'b0;
        step(4'b1111);
        chk("post_rst_gnt", gnt, 4'b0001);
        chk("post_rst_sel", sel, 2'b00);

        // rotation: each owner drops and re-raises its request
        step(4'b1110); chk("rot_bub0", gnt, 4'b0000);
        step(4'b1111); chk("rot_g1", gnt, 4'b0010);
        chk("rot_sel1", sel, 2'b01);
        step(4'b1101); chk("rot_bub1", gnt, 4'b0000);
        step(4'b1111); chk("rot_g2", gnt, 4'b0100);
        step(4'b1011); chk("rot_bub2", gnt, 4'b0000);
        step(4'b1111); chk("rot_g3", gnt, 4'b1000);
        chk("rot_sel3", sel, 2'b11);
        step(4'b0111); chk("rot_bub3", gnt, 4'b0000);
        step(4'b1111); chk("rot_g0", gnt, 4'b0001);

        // lock: requester 2 holds while others toggle
        step(4'b1110); chk("lock_bub", gnt, 4'b0000);
        step(4'b0100); chk("lock_g2", gnt, 4'b0100);
        chk("lock_sel", sel, 2'b10);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] r;
            r = {i[2], 1'b1, i[1], i[0]};
            step(r);
`ifndef ARB_TIMEOUT_EN
            chk("lock_hold", gnt, 4'b0100);
`endif
        end
        step(4'b1010);
`ifndef ARB_TIMEOUT_EN
        chk("lock_rel", gnt, 4'b0000);
`endif
        step(4'b1010);
`ifndef ARB_TIMEOUT_EN
        chk("lock_next", gnt, 4'b1000);
`endif

        // single one-cycle request pulse
        step(4'b0000);
        step(4'b0000);
        chk("pulse_idle", gnt, 4'b0000);
        step(4'b0010);
        chk("pulse_gnt", gnt, 4'b0010);
        chk("pulse_busy", busy, 1'b1);
        step(4'b0000);
        chk("pulse_rel", gnt, 4'b0000);
        chk("pulse_busy0", busy, 1'b0);

        // reset in the middle of a grant
        step(4'b1000);
        chk("mid_g3", gnt, 4'b1000);
        rst = 1'b1;
        step(4'b1111);
        chk("mid_rst_gnt", gnt, 4'b0000);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_pre", preempt, 1'b0);
        rst = 1'b0;
        step(4'b1111);
        chk("mid_after", gnt, 4'b0001);

        // contention between 0 and 1 held constant
        rst = 1'b1;
        step(4'b0011);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step(4'b0011);
            chk("to_g0", gnt, 4'b0001);
        end
        step(4'b0011);
`ifdef ARB_TIMEOUT_EN
        chk("to_bub", gnt, 4'b0000);
        chk("to_pre", preempt, 1'b1);
`else
        chk("to_keep", gnt, 4'b0001);
        chk("to_nopre", preempt, 1'b0);
`endif
        for (int j = 0; j < 4; j++) begin
            step(4'b0011);
`ifdef ARB_TIMEOUT_EN
            chk("to_g1", gnt, 4'b0010);
`else
            chk("to_g0_more", gnt, 4'b0001);
`endif
        end
        step(4'b0011);
`ifdef ARB_TIMEOUT_EN
        chk("to_pre2", preempt, 1'b1);
`endif
        // lone requester keeps the grant without preemption
        step(4'b0001);
        for (int j = 0; j < 10; j++) begin
            step(4'b0001);
            chk("solo_gnt", gnt, 4'b0001);
            chk("solo_pre", preempt, 1'b0);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
